debug_step_unit: RTL
====================

DEBUG_STEP_UNIT -- requirements
Module: debug_step_unit

Interface
REQ-001 Parameter DIGIT, default 32, data/PC width of probe buses.
REQ-002 Parameter DEBUGSIZE, default 8, width of ProbeAddress.
REQ-003 Parameter TIMEOUT, default 16, max cycles one single-step may hold run high.
REQ-004 clock  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cont  input  1  level; 1 = continuous run mode, 0 = single-step mode.
REQ-007 step  input  1  debounced button level; rising edge requests one instruction.
REQ-008 inc  input  1  debounced button level; rising edge increments ProbeAddress.
REQ-009 dec  input  1  debounced button level; rising edge decrements ProbeAddress.
REQ-010 mem_sel  input  1  display source; 1 = ProbeMemData, 0 = ProbeRegData.
REQ-011 InstrDone  input  1  one-cycle pulse from CPU when an instruction completes (return to fetch).
REQ-012 ProbePC  input  DIGIT  current CPU PC.
REQ-013 ProbeRegData  input  DIGIT  register file word at ProbeAddress.
REQ-014 ProbeMemData  input  DIGIT  memory word at ProbeAddress.
REQ-015 run  output  1  CPU enable, registered.
REQ-016 ProbeAddress  output  DEBUGSIZE  debug read address, registered.
REQ-017 DispData  output  DIGIT  captured probe word.
REQ-018 DispPC  output  DIGIT  captured PC.
REQ-019 StepCount  output  16  completed-instruction counter.
REQ-020 err  output  1  sticky step-timeout flag.

Function
REQ-021 Edge detect: step/inc/dec each registered once; edge = current 1 and previous 0; previous registers reset to 0.
REQ-022 FSM states IDLE, STEP, RUN; state register is the only source of run.
REQ-023 IDLE: run=0; cont=1 -> RUN; else step edge -> STEP; timer cleared.
REQ-024 RUN: run=1; cont=0 -> IDLE next cycle (run=0 from that cycle).
REQ-025 STEP: run=1, timer increments each cycle; InstrDone=1 -> IDLE next cycle; timer reaching TIMEOUT-1 without InstrDone -> IDLE and err=1.
REQ-026 STEP: further step edges ignored; cont=1 -> RUN (cont has priority over InstrDone/timeout, err unchanged).
REQ-027 err sticky; cleared only by reset.
REQ-028 ProbeAddress: inc edge alone -> +1, dec edge alone -> -1, modulo 2^DEBUGSIZE (0xFF+1 -> 0x00, 0x00-1 -> 0xFF); simultaneous inc and dec edges -> unchanged.
REQ-029 ProbeAddress changes independent of FSM state.
REQ-030 DispData <= mem_sel ? ProbeMemData : ProbeRegData every cycle; one-cycle latency from address/input change.
REQ-031 DispPC <= ProbePC every cycle; one-cycle latency.
REQ-032 StepCount +1 on each cycle where InstrDone=1 and run=1; wraps 0xFFFF -> 0x0000; InstrDone with run=0 ignored.

Reset
REQ-033 reset=0 asynchronously forces: state IDLE, run=0, ProbeAddress=0, DispData=0, DispPC=0, StepCount=0, err=0, timer=0, edge registers 0.
REQ-034 Reset mid-STEP aborts step immediately (run=0) with no err set.
REQ-035 After reset release with cont=1: run=1 from second rising edge (IDLE -> RUN).
REQ-036 Button held high through reset release produces no edge.

Verification
REQ-037 cont=0, step pulse, InstrDone after 4 cycles -> run high exactly 4+1 cycles then 0; StepCount=1; err=0.
REQ-038 cont=0, step pulse, no InstrDone -> run high TIMEOUT=16 cycles, then run=0, err=1 held until reset.
REQ-039 ProbeAddress=0x00, one dec edge -> 0xFF; one inc edge -> 0x00; inc and dec edges same cycle -> unchanged.
REQ-040 ProbeAddress=0x10, mem_sel=1, ProbeMemData=0x00000008 -> DispData=0x00000008 one cycle later; toggle mem_sel=0, ProbeRegData=0x00000005 -> DispData=0x00000005 next cycle.
REQ-041 cont=1 with InstrDone pulsing every 5 cycles for 50 cycles -> run constantly 1, StepCount=10; cont->0 -> run=0 next cycle.
REQ-042 reset asserted during STEP at cycle 2 -> run=0 immediately, all outputs at reset values, err=0.

Source files
------------

// File: rtl/debug_step_unit.sv
// debug_step_unit: single-step / continuous-run controller for a debug CPU.
// Produces the CPU enable (run), a button-driven probe address, and
// registered snapshots of the probed word and the PC for a display.
module debug_step_unit #(
  parameter int DIGIT     = 32,
  parameter int DEBUGSIZE = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cont,
  input  logic                 step,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 mem_sel,
  input  logic                 InstrDone,
  input  logic [DIGIT-1:0]     ProbePC,
  input  logic [DIGIT-1:0]     ProbeRegData,
  input  logic [DIGIT-1:0]     ProbeMemData,
  output logic                 run,
  output logic [DEBUGSIZE-1:0] ProbeAddress,
  output logic [DIGIT-1:0]     DispData,
  output logic [DIGIT-1:0]     DispPC,
  output logic [15:0]          StepCount,
  output logic                 err,
  output logic [1:0]           dbgState
);

  // CPU handshake: run is a level enable taken straight from the state
  // register; the CPU answers with a one-cycle InstrDone pulse whenever an
  // instruction retires. InstrDone only counts while run is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } stateT;

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  stateT         state, stateNext;
  logic [TW-1:0] timer, timerNext;
  logic          errNext;

  // armed stays low for the first edge after reset so that a button or
  // mode level already present at release is captured, not acted upon.
  logic armed;
  logic stepPrev, incPrev, decPrev;
  logic stepEdge, incEdge, decEdge;

  // Previous-level registers for the three buttons plus the settle flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed    <= 1'b0;
      stepPrev <= 1'b0;
      incPrev  <= 1'b0;
      decPrev  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      stepPrev <= step;
      incPrev  <= inc;
      decPrev  <= dec;
    end
  end

  assign stepEdge = armed & step & ~stepPrev;
  assign incEdge  = armed & inc  & ~incPrev;
  assign decEdge  = armed & dec  & ~decPrev;

  // State, step timer and sticky error register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      err   <= 1'b0;
    end else begin
      state <= stateNext;
      timer <= timerNext;
      err   <= errNext;
    end
  end

  // Next-state logic: cont always wins, then InstrDone, then the timeout.
  always_comb begin
    stateNext = state;
    timerNext = '0;
    errNext   = err;
    if (armed) begin
      case (state)
        IDLE: begin
          if (cont)          stateNext = RUN;
          else if (stepEdge) stateNext = STEP;
        end
        RUN: begin
          if (!cont) stateNext = IDLE;
        end
        STEP: begin
          if (cont) begin
            stateNext = RUN;
          end else if (InstrDone) begin
            stateNext = IDLE;
          end else if (timer == TIMER_LAST) begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end else begin
            timerNext = timer + TW'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end else begin
      timerNext = timer;
    end
  end

  assign run      = (state != IDLE);
  assign dbgState = state;

  // Probe address: a lone inc or dec edge moves it, both together cancel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ProbeAddress <= '0;
    end else begin
      case ({incEdge, decEdge})
        2'b10:   ProbeAddress <= ProbeAddress + DEBUGSIZE'(1);
        2'b01:   ProbeAddress <= ProbeAddress - DEBUGSIZE'(1);
        default: ProbeAddress <= ProbeAddress;
      endcase
    end
  end

  // Display snapshots, refreshed every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      DispData <= '0;
      DispPC   <= '0;
    end else begin
      DispData <= mem_sel ? ProbeMemData : ProbeRegData;
      DispPC   <= ProbePC;
    end
  end

  // Retired-instruction counter; wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      StepCount <= '0;
    end else if (InstrDone && run) begin
      StepCount <= StepCount + 16'd1;
    end
  end

endmodule
